// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states, byte-lane math.
package load_store_unit_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

    // Byte mask across two consecutive words: [3:0] first word, [7:4] the next one.
    function automatic logic [7:0] beat_mask(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SIZE_BYTE: m = 8'h01;
            SIZE_HALF: m = 8'h03;
            default:   m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] m;
        m = beat_mask(off, size);
        return |m[7:4];
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data extraction: shifts the two-word window down by the byte offset and extends.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    logic [31:0] window;

    assign window = 32'({hi, lo} >> {off, 3'b000});

    always_comb begin
        case (size)
            SIZE_BYTE: rdata = {{24{sign_ext & window[7]}}, window[7:0]};
            SIZE_HALF: rdata = {{16{sign_ext & window[15]}}, window[15:0]};
            default:   rdata = window;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, split into up to two word-aligned bus beats.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sign_ext,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [NUM_LANES-1:0]  mem_be,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t state_q, state_d;

    logic                    we_q, sx_q, beat_q, err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, lo_q, hi_q;
    logic [1:0]              size_q;

    logic                    req_cross, cross_q, accept;
    logic [7:0]              mask_q;
    logic [2*DATA_WIDTH-1:0] wide_wdata;
    logic [ADDR_WIDTH-1:0]   word_base, beat_addr;
    logic [DATA_WIDTH-1:0]   load_data;

    assign req_cross  = crosses(req_addr[1:0], req_size);
    assign mask_q     = beat_mask(addr_q[1:0], size_q);
    assign cross_q    = |mask_q[7:4];
    assign accept     = req_valid && req_ready;
    // Low half feeds beat 0, high half holds the bytes spilling into the next word.
    assign wide_wdata = {{DATA_WIDTH{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
    assign word_base  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign beat_addr  = word_base + (beat_q ? ADDR_WIDTH'(4) : '0);

    lsu_load_align u_align (
        .hi       (hi_q),
        .lo       (lo_q),
        .off      (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (sx_q),
        .rdata    (load_data)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = (state_q == LSU_IDLE);
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid)
                    state_d = (req_cross && !ALLOW_MISALIGNED) ? LSU_RESP : LSU_ISSUE;
            end
            LSU_ISSUE: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = beat_addr;
                mem_be    = beat_q ? mask_q[7:4] : mask_q[3:0];
                mem_wdata = beat_q ? wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wide_wdata[DATA_WIDTH-1:0];
                if (mem_ready)
                    state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (mem_rvalid)
                    state_d = (!beat_q && cross_q) ? LSU_ISSUE : LSU_RESP;
            end
            LSU_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : load_data;
                state_d   = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            sx_q    <= 1'b0;
            beat_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                sx_q    <= req_sign_ext;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                beat_q  <= 1'b0;
                err_q   <= req_cross && !ALLOW_MISALIGNED;
                lo_q    <= '0;
                hi_q    <= '0;
            end
            if (state_q == LSU_WAIT && mem_rvalid) begin
                if (beat_q) hi_q <= mem_rdata;
                else        lo_q <= mem_rdata;
                if (!beat_q && cross_q)
                    beat_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, per-cycle scoreboard, directed and random requests.
module tb_load_store_unit;

    typedef struct {
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit        we;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_valid_na, req_we, req_sign_ext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready, rsp_valid, rsp_err, mem_valid, mem_we, mem_ready, mem_rvalid;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        na_req_ready, na_rsp_valid, na_rsp_err, na_mem_valid, na_mem_we;
    logic [31:0] na_rsp_rdata, na_mem_addr, na_mem_wdata;
    logic [3:0]  na_mem_be;
    logic        na_rv = 1'b0;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_sign_ext(req_sign_ext),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_na), .req_ready(na_req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_sign_ext(req_sign_ext),
        .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .rsp_err(na_rsp_err),
        .mem_valid(na_mem_valid), .mem_ready(1'b1), .mem_we(na_mem_we), .mem_addr(na_mem_addr),
        .mem_wdata(na_mem_wdata), .mem_be(na_mem_be), .mem_rvalid(na_rv), .mem_rdata(32'h8899AABB)
    );

    always @(posedge clk) na_rv <= na_mem_valid;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-addressed memory; untouched bytes read as an address-derived pattern.
    bit [7:0] mem [bit [31:0]];

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'hA5);
    endfunction

    function automatic bit [31:0] rd_word(input bit [31:0] w);
        return {rd_byte(w + 3), rd_byte(w + 2), rd_byte(w + 1), rd_byte(w)};
    endfunction

    task automatic set_word(input bit [31:0] w, input bit [31:0] v);
        for (int k = 0; k < 4; k++) mem[w + k] = v[8*k +: 8];
    endtask

    // Memory responder: ready policy and rvalid delay are steered by the directed code.
    int   ready_mode = 2;  // 0 random, 1 held low, 2 held high
    int   delay_mode = 0;  // <0 random 0..2, else fixed
    logic rv_r = 1'b0;
    assign mem_rvalid = rv_r;

    initial begin : responder
        bit        hs, pend;
        int        cnt;
        beat_t     b;
        bit [31:0] rd_addr;
        mem_ready = 1'b0;
        mem_rdata = '0;
        pend = 0; cnt = 0; rd_addr = '0;
        forever begin
            @(negedge clk);
            hs = mem_valid && mem_ready && !rst;
            b  = '{mem_addr, mem_be, mem_wdata, mem_we};
            @(posedge clk); #1;
            rv_r = 1'b0;
            if (hs) begin
                if (b.we)
                    for (int k = 0; k < 4; k++)
                        if (b.be[k]) mem[b.addr + k] = b.wdata[8*k +: 8];
                pend = 1;
                cnt = (delay_mode < 0) ? int'($urandom_range(0, 2)) : delay_mode;
                rd_addr = b.addr;
            end
            if (pend && cnt == 0) begin
                rv_r = 1'b1;
                mem_rdata = rd_word(rd_addr);
                pend = 0;
            end else begin
                if (pend) cnt--;
                mem_rdata = $urandom;
            end
            mem_ready = (ready_mode == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode == 2);
        end
    end

    // Reference model: expectations derived byte by byte from the request.
    beat_t     exp_beats[$], seen_beats[$];
    bit [31:0] exp_rsp[$];
    bit        busy = 0, pend_idle = 0, prev_stall = 0, na_mv_seen = 0;
    beat_t     cur_b, prev_b, exp_b;

    function automatic void model_request(input bit we, input bit [31:0] a, input bit [31:0] wd,
                                          input bit [1:0] sz, input bit sx);
        int        nb;
        bit [31:0] w0, ba, val;
        bit        two;
        beat_t     b0, b1;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        w0  = a & ~32'h3;
        b0  = '{w0, 4'h0, 32'h0, we};
        b1  = '{w0 + 32'd4, 4'h0, 32'h0, we};
        two = 0;
        val = 0;
        for (int k = 0; k < 4; k++) begin
            ba = a + k;
            if ((ba & ~32'h3) == w0) begin
                b0.wdata[8*ba[1:0] +: 8] = wd[8*k +: 8];
                if (k < nb) b0.be[ba[1:0]] = 1'b1;
            end else begin
                b1.wdata[8*ba[1:0] +: 8] = wd[8*k +: 8];
                if (k < nb) begin b1.be[ba[1:0]] = 1'b1; two = 1; end
            end
            if (k < nb) val[8*k +: 8] = rd_byte(ba);
        end
        if (sx && nb < 4 && val[8*nb-1]) val = val | (32'hFFFFFFFF << (8*nb));
        exp_beats.push_back(b0);
        if (two) exp_beats.push_back(b1);
        exp_rsp.push_back(we ? 32'h0 : val);
    endfunction

    initial begin : model
        forever begin
            @(negedge clk);
            if (na_mem_valid) na_mv_seen = 1;
            if (rst) begin
                exp_beats.delete();
                exp_rsp.delete();
                busy = 0; pend_idle = 0; prev_stall = 0;
                continue;
            end
            if (pend_idle) begin busy = 0; pend_idle = 0; end
            chk("req_ready", req_ready, !busy);
            cur_b = '{mem_addr, mem_be, mem_wdata, mem_we};
            if (prev_stall) begin
                chk("stall_ctl", {mem_valid, mem_we, mem_be, mem_addr}, {1'b1, prev_b.we, prev_b.be, prev_b.addr});
                chk("stall_wdata", mem_wdata, prev_b.wdata);
            end
            if (mem_valid && mem_ready) begin
                seen_beats.push_back(cur_b);
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat: unexpected beat addr %h be %b", mem_addr, mem_be);
                end else begin
                    exp_b = exp_beats.pop_front();
                    chk("beat_ctl", {mem_we, mem_be, mem_addr}, {exp_b.we, exp_b.be, exp_b.addr});
                    chk("beat_wdata", mem_wdata, exp_b.wdata);
                end
            end
            prev_stall = mem_valid && !mem_ready;
            prev_b = cur_b;
            if (rsp_valid) begin
                chk("beats_done", exp_beats.size(), 0);
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp: unexpected rsp_valid rdata %h", rsp_rdata);
                end else begin
                    chk("rsp", {rsp_err, rsp_rdata}, {1'b0, exp_rsp.pop_front()});
                end
                pend_idle = 1;
            end
            if (req_valid && req_ready) begin
                model_request(req_we, req_addr, req_wdata, req_size, req_sign_ext);
                busy = 1;
            end
        end
    end

    task automatic do_req(input bit na, input bit we, input bit [31:0] a, input bit [31:0] wd,
                          input bit [1:0] sz, input bit sx,
                          output bit [31:0] rd, output bit er, output int lat);
        bit acc, got;
        acc = 0; got = 0; rd = '0; er = 0; lat = 0;
        @(posedge clk); #1;
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_sign_ext = sx;
        if (na) req_valid_na = 1'b1; else req_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = na ? na_req_ready : req_ready;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid_na = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_size = $urandom; req_sign_ext = $urandom;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready never seen, addr %h", a);
        end
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            lat++;
            if (na ? na_rsp_valid : rsp_valid) begin
                got = 1;
                rd  = na ? na_rsp_rdata : rsp_rdata;
                er  = na ? na_rsp_err : rsp_err;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid, addr %h", a);
        end
    endtask

    bit [31:0] rd;
    bit        er;
    int        lat;
    bit [31:0] snap_addr, snap_wdata, ra;
    bit [3:0]  snap_be;
    bit        snap_we, found;

    initial begin : main
        rst = 1'b1;
        req_valid = 1'b0; req_valid_na = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_size = '0; req_sign_ext = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {req_ready, rsp_valid, rsp_err, mem_valid, mem_we, mem_be}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        chk("reset_addr", mem_addr, 0);
        chk("reset_data", {mem_wdata, rsp_rdata}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Store word, aligned
        seen_beats.delete();
        do_req(0, 1, 32'h100, 32'hDEADBEEF, 2'd2, 0, rd, er, lat);
        chk("t1_nbeats", seen_beats.size(), 1);
        if (seen_beats.size() > 0)
            chk("t1_beat", {seen_beats[0].we, seen_beats[0].be, seen_beats[0].addr, seen_beats[0].wdata},
                {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF});
        chk("t1_rsp", {er, rd}, 0);
        chk("t1_lat", lat, 3);

        // Byte load, sign and zero extension
        set_word(32'h100, 32'h80112233);
        seen_beats.delete();
        do_req(0, 0, 32'h103, 32'h0, 2'd0, 1, rd, er, lat);
        chk("t2_sx", {er, rd}, {1'b0, 32'hFFFFFF80});
        if (seen_beats.size() > 0) chk("t2_be", {seen_beats[0].be, seen_beats[0].addr}, {4'b1000, 32'h100});
        do_req(0, 0, 32'h103, 32'h0, 2'd0, 0, rd, er, lat);
        chk("t2_zx", {er, rd}, {1'b0, 32'h00000080});

        // Split word load
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        seen_beats.delete();
        do_req(0, 0, 32'h102, 32'h0, 2'd2, 0, rd, er, lat);
        chk("t3_rdata", {er, rd}, {1'b0, 32'h66554433});
        chk("t3_nbeats", seen_beats.size(), 2);
        if (seen_beats.size() == 2) begin
            chk("t3_beat0", {seen_beats[0].be, seen_beats[0].addr}, {4'b1100, 32'h100});
            chk("t3_beat1", {seen_beats[1].be, seen_beats[1].addr}, {4'b0011, 32'h104});
        end
        chk("t3_lat", lat, 5);

        // Split half store
        seen_beats.delete();
        do_req(0, 1, 32'h103, 32'h0000ABCD, 2'd1, 0, rd, er, lat);
        chk("t4_nbeats", seen_beats.size(), 2);
        if (seen_beats.size() == 2) begin
            chk("t4_beat0", {seen_beats[0].be, seen_beats[0].addr, seen_beats[0].wdata}, {4'b1000, 32'h100, 32'hCD000000});
            chk("t4_beat1", {seen_beats[1].be, seen_beats[1].addr, seen_beats[1].wdata}, {4'b0001, 32'h104, 32'h000000AB});
        end
        chk("t4_mem", {rd_word(32'h100), rd_word(32'h104)}, {32'hCD332211, 32'h887766AB});

        // Misaligned access with splitting disabled
        na_mv_seen = 0;
        do_req(1, 0, 32'h102, 32'h0, 2'd2, 1, rd, er, lat);
        chk("t5_err", {er, rd}, {1'b1, 32'h0});
        chk("t5_lat", lat, 1);
        chk("t5_no_bus", na_mv_seen, 0);
        do_req(1, 0, 32'h101, 32'h0, 2'd1, 0, rd, er, lat);
        chk("t5_half_ok", {er, rd}, {1'b0, 32'h000099AA});
        do_req(1, 1, 32'h103, 32'h12, 2'd0, 0, rd, er, lat);
        chk("t5_store_ok", {er, rd}, 0);

        // Back-pressure hold, then reset in WAIT followed by a stray rvalid
        ready_mode = 1; delay_mode = 4;
        @(posedge clk); #1;
        req_we = 1; req_addr = 32'h120; req_wdata = 32'h5A5A1234; req_size = 2'd2; req_sign_ext = 0;
        req_valid = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin @(negedge clk); found = req_ready; end
        @(posedge clk); #1 req_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin @(negedge clk); found = mem_valid; end
        chk("t6_issue", found, 1);
        snap_addr = mem_addr; snap_be = mem_be; snap_wdata = mem_wdata; snap_we = mem_we;
        repeat (5) begin
            @(negedge clk);
            chk("t6_hold_ctl", {mem_valid, mem_ready, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, snap_we, snap_be, snap_addr});
            chk("t6_hold_wdata", mem_wdata, snap_wdata);
        end
        chk("t6_snap", {snap_we, snap_be, snap_addr, snap_wdata}, {1'b1, 4'hF, 32'h120, 32'h5A5A1234});
        ready_mode = 2;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin @(negedge clk); found = mem_valid && mem_ready; end
        chk("t6_hs", found, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("t6_idle", {req_ready, rsp_valid, mem_valid}, 3'b100);
        end
        delay_mode = 0;

        // Randomized traffic, including wrap at the top of the address space
        ready_mode = 0; delay_mode = -1;
        repeat (300) begin
            ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + $urandom_range(0, 7))
                                             : (32'h100 + $urandom_range(0, 31));
            do_req(0, 1'($urandom), ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), rd, er, lat);
        end

        repeat (5) @(negedge clk);
        chk("queues_empty", exp_beats.size() + exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
